wb_grf: RTL
===========

# wb_grf

Write-back stage and general register file of the five-stage MIPS pipeline. Consumes the W-stage pipeline-register outputs and selects the write-back data from ALU result, data-memory read data, extended immediate or PC+8. Commits that data into a 32×32-bit register file and serves two combinational read ports to the D stage, with internal W→D bypass. Also drives the evaluation-harness write trace and a committed-write counter.

## Interface
- No parameters; register count (32) and data width (32) are fixed by the ISA.
- clk  input  1  pipeline clock; all state updates on posedge clk.
- RESET  input  1  synchronous, active-high reset, sampled on posedge clk.
- W_GRFWE  input  1  register-write enable of the W-stage instruction.
- W_GRF_WD_W_Sel  input  2  write-data select: 00 W_OP, 01 W_DM_Q, 10 W_ext32, 11 W_pc8.
- W_OP  input  32  ALU/MDU result.
- W_DM_Q  input  32  data-memory load data, already sub-word extended.
- W_ext32  input  32  extended immediate (lui).
- W_pc8  input  32  PC+8 (jal/jalr link value).
- W_GRF_A3  input  5  destination register number.
- W_Exam_InstrAddr  input  32  PC of the W-stage instruction.
- D_GRF_A1  input  5  read port 1 register number.
- D_GRF_A2  input  5  read port 2 register number.
- D_GRF_RD1  output  32  read port 1 data.
- D_GRF_RD2  output  32  read port 2 data.
- Exam_GRF_WE  output  1  trace: a committed write happens this cycle.
- Exam_GRF_A3  output  5  trace: destination register.
- Exam_GRF_WD  output  32  trace: write data.
- Exam_InstrAddr  output  32  trace: PC of the writing instruction.
- Q_WriteCount  output  32  number of committed writes since reset.

## Operation
- WD = mux(W_GRF_WD_W_Sel) as encoded above; purely combinational.
- Commit condition C = !RESET && W_GRFWE && (W_GRF_A3 != 0).
- On posedge clk: if RESET, all 32 registers ← 0 and Q_WriteCount ← 0; else if C, reg[W_GRF_A3] ← WD and Q_WriteCount ← Q_WriteCount + 1 (mod 2^32, wraps 0xFFFFFFFF → 0).
- Register 0 is hard zero: writes to it never change state, never count, never trace.
- Read port n: if A_n == 0 → 0; else if W_GRFWE && W_GRF_A3 == A_n → WD (bypass); else reg[A_n].
- Bypass is not gated by RESET: during reset the W register itself is being cleared, so its inputs are zero.
- Trace outputs: Exam_GRF_WE = C; Exam_GRF_A3 = W_GRF_A3; Exam_GRF_WD = WD; Exam_InstrAddr = W_Exam_InstrAddr. All are unconditional copies except WE.
- No stall or flush inputs; upstream inserts bubbles as W_GRFWE = 0.

## Timing
- Read ports, trace outputs and WD: combinational, zero latency.
- Write latency: data presented in cycle N is visible in reg[] from cycle N+1. The bypass makes it visible on D_GRF_RD* already in cycle N, so no extra W→D forwarding mux is needed upstream.
- Reset values, first cycle after a RESET edge: every register 0, Q_WriteCount 0. RD1/RD2 are 0 unless a bypass hit occurs. Exam_GRF_WE is 0 while RESET is high.
- Reset mid-operation: RESET wins over a simultaneous write; the write is discarded, not counted and not traced.
- Same register on both read ports: both ports return identical data, including when bypassed.

## Test plan
- Reset then read: assert RESET for 1 cycle, A1=5, A2=31 → RD1=RD2=0, Q_WriteCount=0, Exam_GRF_WE=0.
- Select coverage: write $8 with Sel 00/01/10/11, carrying W_OP=0x11, W_DM_Q=0x22, W_ext32=0x33, W_pc8=0x3008 on successive cycles → $8 holds each value the next cycle; trace shows A3=8 and matching WD; count reaches 4.
- Bypass: GRFWE=1, A3=9, W_OP=0xDEADBEEF, A1=A2=9 in the same cycle → RD1=RD2=0xDEADBEEF before the edge; reg[9]=0xDEADBEEF after.
- $0 protection: GRFWE=1, A3=0, WD=0xFFFFFFFF, A1=0 → RD1=0, Exam_GRF_WE=0, count unchanged; $0 still reads 0 next cycle.
- Reset vs write: RESET=1 and GRFWE=1, A3=3, W_OP=7 in the same cycle → after the edge $3=0 and count=0.
- Counter and random: 1000 random writes checked against a reference model array → all reads match; count equals the number of writes with A3≠0.

Source files
------------

// File: rtl/wb_grf.sv
// Write-back select and 32x32 register file. Reads, WD and trace are combinational;
// a commit lands in the file on the next clock edge. There is no backpressure: W_GRFWE=0 is a bubble.
module wb_grf (
  input  logic        clk,
  input  logic        RESET,
  input  logic        W_GRFWE,
  input  logic [1:0]  W_GRF_WD_W_Sel,
  input  logic [31:0] W_OP,
  input  logic [31:0] W_DM_Q,
  input  logic [31:0] W_ext32,
  input  logic [31:0] W_pc8,
  input  logic [4:0]  W_GRF_A3,
  input  logic [31:0] W_Exam_InstrAddr,
  input  logic [4:0]  D_GRF_A1,
  input  logic [4:0]  D_GRF_A2,
  output logic [31:0] D_GRF_RD1,
  output logic [31:0] D_GRF_RD2,
  output logic        Exam_GRF_WE,
  output logic [4:0]  Exam_GRF_A3,
  output logic [31:0] Exam_GRF_WD,
  output logic [31:0] Exam_InstrAddr,
  output logic [31:0] Q_WriteCount
);

  logic [31:0] rf_q [32];
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] wd;
  logic        commit;
  logic        byp1, byp2;

  always_comb begin
    wd = W_OP;
    case (W_GRF_WD_W_Sel)
      2'b00:   wd = W_OP;
      2'b01:   wd = W_DM_Q;
      2'b10:   wd = W_ext32;
      default: wd = W_pc8;
    endcase
  end

  assign commit = !RESET && W_GRFWE && (W_GRF_A3 != 5'd0);

  // Bypass ignores RESET on purpose: the W register feeding us is zeroed during reset.
  assign byp1 = W_GRFWE && (W_GRF_A3 == D_GRF_A1);
  assign byp2 = W_GRFWE && (W_GRF_A3 == D_GRF_A2);

  always_comb begin
    D_GRF_RD1 = rf_q[D_GRF_A1];
    if (D_GRF_A1 == 5'd0)
      D_GRF_RD1 = 32'd0;
    else if (byp1)
      D_GRF_RD1 = wd;
  end

  always_comb begin
    D_GRF_RD2 = rf_q[D_GRF_A2];
    if (D_GRF_A2 == 5'd0)
      D_GRF_RD2 = 32'd0;
    else if (byp2)
      D_GRF_RD2 = wd;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= 32'd0;
    end else if (commit) begin
      rf_q[W_GRF_A3] <= wd;
    end
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (commit)
      wcnt_d = wcnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (RESET)
      wcnt_q <= 32'd0;
    else
      wcnt_q <= wcnt_d;
  end

  assign Q_WriteCount   = wcnt_q;
  assign Exam_GRF_WE    = commit;
  assign Exam_GRF_A3    = W_GRF_A3;
  assign Exam_GRF_WD    = wd;
  assign Exam_InstrAddr = W_Exam_InstrAddr;

endmodule
